// File: rtl/nbitadd_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package nbitadd_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} add_state_t;
endpackage

// File: rtl/fulladd.sv
// Single-bit full adder cell, combinational; the one arithmetic cell of the serial adder.
module fulladd (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/nbitserialadd.sv
// Bit-serial n-bit adder: LSB-first through one full-adder cell and a carry flop.
// Optional SERIAL_ADD_SAT_EN: saturate y to all-ones on carry-out.
module nbitserialadd
  import nbitadd_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] y,
  output logic         cout,
  output logic         busy,
  output logic         done
);
  localparam int CW = $clog2(n + 1);

  add_state_t   state, state_nx;
  logic [n-1:0] opa, opb, acc, acc_nx;
  logic [CW-1:0] cnt;
  logic         carry, fa_s, fa_c, load, last;

  fulladd u_fa (.a(opa[0]), .b(opb[0]), .cin(carry), .s(fa_s), .cout(fa_c));

  assign last = (state == RUN) && (cnt == CW'(n - 1));

  // Sum bit enters at the MSB so after n shifts bit 0 sits at acc[0]; also valid for n=1.
  always_comb begin
    acc_nx        = acc >> 1;
    acc_nx[n-1]   = fa_s;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: if (start) begin
        load     = 1'b1;
        state_nx = RUN;
      end
      RUN:  if (last) state_nx = DONE;
      DONE: begin
        load     = start;
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      y     <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        opa   <= a;
        opb   <= b;
        acc   <= '0;
        carry <= 1'b0;
        cnt   <= '0;
      end else if (state == RUN) begin
        acc   <= acc_nx;
        carry <= fa_c;
        opa   <= opa >> 1;
        opb   <= opb >> 1;
        cnt   <= cnt + CW'(1);
        if (last) begin
`ifdef SERIAL_ADD_SAT_EN
          y <= fa_c ? '1 : acc_nx;
`else
          y <= acc_nx;
`endif
          cout <= fa_c;
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule

// File: tb/tb_nbitserialadd.sv
// Scoreboard bench for nbitserialadd at n=4, n=1 and n=8.
module tb_nbitserialadd;
  logic clk = 1'b0, rst_n = 1'b0;
  logic       start4 = 0, start1 = 0, start8 = 0;
  logic [3:0] a4 = 0, b4 = 0, y4;
  logic [0:0] a1 = 0, b1 = 0, y1;
  logic [7:0] a8 = 0, b8 = 0, y8;
  logic cout4, busy4, done4, cout1, busy1, done1, cout8, busy8, done8;

  typedef struct { logic c; logic [7:0] y; } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  nbitserialadd #(.n(4)) u4 (.clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .y(y4), .cout(cout4), .busy(busy4), .done(done4));
  nbitserialadd #(.n(1)) u1 (.clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .y(y1), .cout(cout1), .busy(busy1), .done(done1));
  nbitserialadd #(.n(8)) u8 (.clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .y(y8), .cout(cout8), .busy(busy8), .done(done8));

  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [8:0] s, m;
    m   = (9'h1 << w) - 9'h1;
    s   = {1'b0, a & m[7:0]} + {1'b0, b & m[7:0]};
    e.c = s[w];
    e.y = s[7:0] & m[7:0];
`ifdef SERIAL_ADD_SAT_EN
    if (e.c) e.y = m[7:0];
`endif
    return e;
  endfunction

  function automatic exp_t actual(input int w);
    exp_t e;
    case (w)
      1:       begin e.c = cout1; e.y = {7'b0, y1}; end
      4:       begin e.c = cout4; e.y = {4'b0, y4}; end
      default: begin e.c = cout8; e.y = y8; end
    endcase
    return e;
  endfunction

  // Drive a start pulse and return just after the accepting edge.
  task automatic issue(input int w, input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    case (w)
      1:       begin a1 = a[0:0]; b1 = b[0:0]; start1 = 1; end
      4:       begin a4 = a[3:0]; b4 = b[3:0]; start4 = 1; end
      default: begin a8 = a;      b8 = b;      start8 = 1; end
    endcase
    q.push_back(model(w, a, b));
    @(posedge clk); #1;
    start1 = 0; start4 = 0; start8 = 0;
  endtask

  // Counts negedges until done; lat is the negedge index of done, bc the busy cycles seen before it.
  task automatic wait_done(input int w, output bit got, output int lat, output int bc);
    logic d, bs;
    got = 0; lat = -1; bc = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      d  = (w == 1) ? done1 : (w == 4) ? done4 : done8;
      bs = (w == 1) ? busy1 : (w == 4) ? busy4 : busy8;
      if (d) begin got = 1; lat = i; end
      else if (bs) bc++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({y4, cout4, busy4, done4, y1, cout1, busy1, done1, y8, cout8, busy8, done8} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got y4=%0d c4=%0d b4=%0d d4=%0d y8=%0d d8=%0d, want all 0",
               y4, cout4, busy4, done4, y8, done8);
    end
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic test_basic(input logic [3:0] a, input logic [3:0] b, input string nm);
    bit got; int lat, bc; exp_t e, x;
    issue(4, {4'b0, a}, {4'b0, b});
    wait_done(4, got, lat, bc);
    total++;
    if (!got) begin bad++; $display("FAIL %s_timeout: no done within bound", nm); q.delete(); return; end
    e = q.pop_front(); x = actual(4);
    if (x !== e) begin bad++; $display("FAIL %s_result: got c=%0d y=%0d want c=%0d y=%0d", nm, x.c, x.y, e.c, e.y); end
    total++;
    if (lat !== 4 || bc !== 4) begin bad++; $display("FAIL %s_timing: got lat=%0d busy=%0d want 4/4", nm, lat, bc); end
    @(negedge clk);
    total++;
    if (done4 !== 1'b0) begin bad++; $display("FAIL %s_done_pulse: got done=%0d a cycle later, want 0", nm, done4); end
  endtask

  task automatic test_start_held;
    bit got; int lat, bc; exp_t e, x; int extra = 0;
    @(posedge clk); #1 a4 = 9; b4 = 6; start4 = 1;
    q.push_back(model(4, 8'd9, 8'd6));
    @(posedge clk); #1 a4 = 0;
    repeat (3) @(posedge clk);
    #1 start4 = 0;
    wait_done(4, got, lat, bc);
    total++;
    if (!got) begin bad++; $display("FAIL held_timeout: no done within bound"); q.delete(); return; end
    e = q.pop_front(); x = actual(4);
    if (x !== e) begin bad++; $display("FAIL held_result: got c=%0d y=%0d want c=%0d y=%0d", x.c, x.y, e.c, e.y); end
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (done4) extra++; end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL held_single_done: got %0d extra done pulses want 0", extra); end
  endtask

  task automatic test_back_to_back;
    bit got; int lat, bc; exp_t e, x;
    issue(4, 8'd3, 8'd5);
    wait_done(4, got, lat, bc);
    total++;
    if (!got) begin bad++; $display("FAIL b2b_first_timeout: no done"); q.delete(); return; end
    e = q.pop_front(); x = actual(4);
    if (x !== e) begin bad++; $display("FAIL b2b_first: got c=%0d y=%0d want c=%0d y=%0d", x.c, x.y, e.c, e.y); end
    a4 = 2; b4 = 2; start4 = 1;
    q.push_back(model(4, 8'd2, 8'd2));
    @(posedge clk); #1 start4 = 0;
    wait_done(4, got, lat, bc);
    total++;
    if (!got) begin bad++; $display("FAIL b2b_second_timeout: no done"); q.delete(); return; end
    e = q.pop_front(); x = actual(4);
    if (x !== e) begin bad++; $display("FAIL b2b_second: got c=%0d y=%0d want c=%0d y=%0d", x.c, x.y, e.c, e.y); end
    total++;
    if (lat !== 4 || bc !== 4) begin bad++; $display("FAIL b2b_gap: got lat=%0d busy=%0d want 4/4", lat, bc); end
  endtask

  task automatic test_reset_abort;
    int extra = 0;
    issue(4, 8'd3, 8'd3);
    @(posedge clk); #1 rst_n = 0;
    void'(q.pop_back());
    @(negedge clk);
    total++;
    if ({y4, cout4, busy4, done4} !== 7'b0) begin
      bad++; $display("FAIL abort_outputs: got y=%0d c=%0d busy=%0d done=%0d want 0", y4, cout4, busy4, done4);
    end
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (done4 || busy4) extra++; end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL abort_no_done: got %0d busy/done cycles want 0", extra); end
    test_basic(4'd1, 4'd1, "after_abort");
  endtask

  task automatic test_n1;
    bit got; int lat, bc; exp_t e, x;
    issue(1, 8'd1, 8'd1);
    wait_done(1, got, lat, bc);
    total++;
    if (!got) begin bad++; $display("FAIL n1_timeout: no done"); q.delete(); return; end
    e = q.pop_front(); x = actual(1);
    if (x !== e) begin bad++; $display("FAIL n1_result: got c=%0d y=%0d want c=%0d y=%0d", x.c, x.y, e.c, e.y); end
    total++;
    if (lat !== 1 || bc !== 1) begin bad++; $display("FAIL n1_timing: got lat=%0d busy=%0d want 1/1", lat, bc); end
  endtask

  task automatic test_random8;
    bit got; int lat, bc; exp_t e, x;
    for (int i = 0; i < 1000; i++) begin
      issue(8, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_done(8, got, lat, bc);
      total++;
      if (!got) begin bad++; $display("FAIL rand8_timeout: vector %0d no done", i); q.delete(); return; end
      e = q.pop_front(); x = actual(8);
      if (x !== e || lat !== 8) begin
        bad++;
        $display("FAIL rand8_%0d: got c=%0d y=%0d lat=%0d want c=%0d y=%0d lat=8", i, x.c, x.y, lat, e.c, e.y);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic(4'd3, 4'd5, "add_3_5");
    test_basic(4'd15, 4'd1, "add_15_1");
    test_basic(4'd15, 4'd15, "add_15_15");
    test_basic(4'd0, 4'd0, "add_0_0");
    test_start_held();
    test_back_to_back();
    test_reset_abort();
    test_n1();
    test_random8();
    total++;
    if (q.size() !== 0) begin bad++; $display("FAIL scoreboard_drain: got %0d outstanding want 0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
